// File: rtl/uart_ir_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_ir_loader
// Description : 8N1 UART receiver that packs byte pairs (high byte first) into
//               16-bit words and writes them sequentially into instruction RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ir_loader #(
   parameter int CLKS_PER_BIT = 347,
   parameter int IDLE_BITS    = 32,
   parameter int ADDR_W       = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx,
   output logic [15:0]       mem_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wren,
   output logic              loading,
   output logic              load_done,
   output logic [ADDR_W:0]   word_count,
   output logic              frame_err
);

   localparam int c_tmr_w      = $clog2(CLKS_PER_BIT);
   localparam int c_idle_limit = IDLE_BITS * CLKS_PER_BIT;
   localparam int c_idle_w     = $clog2(c_idle_limit + 1);

   localparam logic [c_tmr_w-1:0]  c_half_tick = c_tmr_w'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_tmr_w-1:0]  c_full_tick = c_tmr_w'(CLKS_PER_BIT - 1);
   localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(c_idle_limit - 1);
   localparam logic [ADDR_W-1:0]   c_last_addr = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } rx_state_t;

   rx_state_t           r_state;
   logic                r_rx_meta;
   logic                r_rx_s;
   logic [c_tmr_w-1:0]  r_timer;
   logic [2:0]          r_bit_idx;
   logic [7:0]          r_shift;
   logic                r_byte_valid;
   logic                r_phase_hi;
   logic [7:0]          r_hi;
   logic [c_idle_w-1:0] r_idle_cnt;

   // Two-flop synchronizer; resets to the idle-high line level.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_timer      <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_phase_hi   <= 1'b1;
         r_hi         <= '0;
         r_idle_cnt   <= '0;
         mem_data     <= '0;
         mem_addr     <= '0;
         mem_wren     <= 1'b0;
         loading      <= 1'b0;
         load_done    <= 1'b0;
         word_count   <= '0;
         frame_err    <= 1'b0;
      end else begin
         r_byte_valid <= 1'b0;
         mem_wren     <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (!load_done && !r_rx_s) begin
                  r_state <= S_START;
                  r_timer <= '0;
               end
            end
            S_START: begin
               if (r_timer == c_half_tick) begin
                  r_timer <= '0;
                  if (!r_rx_s) begin
                     r_state   <= S_DATA;
                     r_bit_idx <= '0;
                     if (!load_done) loading <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_DATA: begin
               if (r_timer == c_full_tick) begin
                  r_timer <= '0;
                  r_shift <= {r_rx_s, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) r_state <= S_STOP;
                  else                   r_bit_idx <= r_bit_idx + 1'b1;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_STOP: begin
               if (r_timer == c_full_tick) begin
                  r_timer <= '0;
                  r_state <= S_IDLE;
                  if (r_rx_s) r_byte_valid <= 1'b1;
                  else        frame_err    <= 1'b1;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Word assembly: first byte of a pair is held, second triggers the write.
         if (r_byte_valid && !load_done) begin
            if (r_phase_hi) begin
               r_hi       <= r_shift;
               r_phase_hi <= 1'b0;
            end else begin
               mem_data <= {r_hi, r_shift};
               mem_wren <= 1'b1;
            end
         end

         if (mem_wren) begin
            mem_addr   <= mem_addr + 1'b1;
            word_count <= word_count + 1'b1;
            r_phase_hi <= 1'b1;
            if (mem_addr == c_last_addr) begin
               loading   <= 1'b0;
               load_done <= 1'b1;
            end
         end

         // Idle timeout only arms once a load is underway; any line activity restarts it.
         if (loading && (r_state == S_IDLE) && r_rx_s) begin
            if (r_idle_cnt == c_idle_last) begin
               r_idle_cnt <= '0;
               loading    <= 1'b0;
               load_done  <= 1'b1;
            end else begin
               r_idle_cnt <= r_idle_cnt + 1'b1;
            end
         end else begin
            r_idle_cnt <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_ir_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_ir_loader
// Description : Randomized scoreboard bench for uart_ir_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ir_loader;

   localparam int CPB   = 4;
   localparam int IB    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          rx    = 1'b1;
   logic [15:0]   mem_data;
   logic [AW-1:0] mem_addr;
   logic          mem_wren;
   logic          loading;
   logic          load_done;
   logic [AW:0]   word_count;
   logic          frame_err;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [19:0]   exp_q[$];
   logic [19:0]   mon_e;
   logic [7:0]    byte_buf[64];
   bit            stop_buf[64];
   int            n_bytes;
   int            exp_words;
   bit            exp_ferr;

   uart_ir_loader #(
      .CLKS_PER_BIT(CPB),
      .IDLE_BITS   (IB),
      .ADDR_W      (AW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .rx        (rx),
      .mem_data  (mem_data),
      .mem_addr  (mem_addr),
      .mem_wren  (mem_wren),
      .loading   (loading),
      .load_done (load_done),
      .word_count(word_count),
      .frame_err (frame_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every write strobe is matched against the scoreboard head.
   always @(negedge clock) begin
      if (!reset && mem_wren) begin
         check("wren_while_done", 32'(load_done), 32'd0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr %0d data 0x%04h, no write expected",
                     mem_addr, mem_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr_data", 32'({mem_addr, mem_data}), 32'(mon_e));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      repeat (CPB) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit good_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(good_stop);
      if (!good_stop) send_bit(1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rx    = 1'b1;
      repeat (4) tick();
      exp_q.delete();
      reset = 1'b0;
      repeat (3) tick();
      check("rst_wren",       32'(mem_wren),   32'd0);
      check("rst_addr",       32'(mem_addr),   32'd0);
      check("rst_data",       32'(mem_data),   32'd0);
      check("rst_loading",    32'(loading),    32'd0);
      check("rst_load_done",  32'(load_done),  32'd0);
      check("rst_word_count", 32'(word_count), 32'd0);
      check("rst_frame_err",  32'(frame_err),  32'd0);
   endtask

   // Reference: good-stop bytes pair up high-first into consecutive words
   // until the RAM is full; nothing after that point has any effect.
   task automatic build_model();
      logic [7:0] hi;
      bit         have_hi;
      have_hi   = 1'b0;
      hi        = '0;
      exp_words = 0;
      exp_ferr  = 1'b0;
      for (int i = 0; i < n_bytes; i++) begin
         if (exp_words == DEPTH) break;
         if (!stop_buf[i]) begin
            exp_ferr = 1'b1;
         end else if (!have_hi) begin
            hi      = byte_buf[i];
            have_hi = 1'b1;
         end else begin
            exp_q.push_back({AW'(exp_words), hi, byte_buf[i]});
            exp_words++;
            have_hi = 1'b0;
         end
      end
   endtask

   task automatic run_stream(input string tag);
      int waited;
      build_model();
      for (int i = 0; i < n_bytes; i++) begin
         send_byte(byte_buf[i], stop_buf[i]);
         if (i == 0) check({tag, "_loading_after_first"}, 32'(loading), 32'd1);
         repeat ($urandom_range(0, 2)) send_bit(1'b1);
      end
      rx = 1'b1;
      if (exp_words < DEPTH) begin
         repeat (10) tick();
         check({tag, "_not_done_early"}, 32'(load_done), 32'd0);
      end
      waited = 0;
      while (!load_done && waited < 400) begin
         tick();
         waited++;
      end
      repeat (4) tick();
      check({tag, "_load_done"},  32'(load_done),    32'd1);
      check({tag, "_loading"},    32'(loading),      32'd0);
      check({tag, "_word_count"}, 32'(word_count),   32'(exp_words));
      check({tag, "_frame_err"},  32'(frame_err),    32'(exp_ferr));
      check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic load_list(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int n);
      byte_buf[0] = b0; byte_buf[1] = b1; byte_buf[2] = b2; byte_buf[3] = b3;
      for (int i = 0; i < 4; i++) stop_buf[i] = 1'b1;
      n_bytes = n;
   endtask

   initial begin
      do_reset();

      load_list(8'h12, 8'h34, 8'h56, 8'h78, 4);
      run_stream("four_bytes");

      do_reset();
      load_list(8'hAB, 8'hCD, 8'hEF, 8'h00, 3);
      run_stream("odd_bytes");

      // Single-cycle glitch must look like a false start.
      do_reset();
      rx = 1'b0;
      tick();
      rx = 1'b1;
      repeat (100) tick();
      check("glitch_loading",    32'(loading),    32'd0);
      check("glitch_load_done",  32'(load_done),  32'd0);
      check("glitch_word_count", 32'(word_count), 32'd0);

      do_reset();
      load_list(8'h12, 8'h34, 8'h56, 8'h00, 3);
      stop_buf[0] = 1'b0;
      run_stream("frame_err");

      do_reset();
      for (int i = 0; i < 34; i++) begin
         byte_buf[i] = 8'(i);
         stop_buf[i] = 1'b1;
      end
      n_bytes = 34;
      run_stream("fill_ram");

      // Reset in the middle of the second byte abandons everything.
      do_reset();
      send_byte(8'h11, 1'b1);
      check("pre_reset_loading", 32'(loading), 32'd1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      do_reset();
      load_list(8'h9A, 8'hBC, 8'h00, 8'h00, 2);
      run_stream("after_reset");

      for (int r = 0; r < 6; r++) begin
         do_reset();
         n_bytes = $urandom_range(1, 40);
         for (int i = 0; i < n_bytes; i++) begin
            byte_buf[i] = 8'($urandom);
            stop_buf[i] = ($urandom_range(0, 7) != 0);
         end
         run_stream($sformatf("rand%0d", r));
      end

      repeat (5) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
